// File: rtl/add8_arb_pkg.sv
// Shared constants for the two-client adder scheduler: FSM encodings, tie-pointer
// reset value and the round-robin pick rule.
package add8_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_EXEC  = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    // Pointer names the client served last; starting at 1 lets client 0 win the first tie.
    localparam logic       LAST_RST = 1'b1;

    function automatic logic rr_pick1(input logic req0, input logic req1, input logic last);
        return req1 && (!req0 || !last);
    endfunction

endpackage

// File: rtl/add8_arbiter_cla8.sv
// 8-bit adder built from two chained 4-bit carry look-ahead blocks.
// Purely combinational.
module cla8
    import add8_arb_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_ci,
    output logic [7:0] o_s,
    output logic       o_co
);

    logic [7:0] w_g;
    logic [7:0] w_p;
    logic [4:0] w_lo;
    logic [4:0] w_hi;

    // Returns {carry_out, sum[3:0]} of one look-ahead block.
    function automatic logic [4:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic c0);
        logic c1, c2, c3, c4;
        c1 = g[0] | (p[0] & c0);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
        return {c4, p ^ {c3, c2, c1, c0}};
    endfunction

    assign w_g  = i_a & i_b;
    assign w_p  = i_a ^ i_b;
    assign w_lo = cla4(w_g[3:0], w_p[3:0], i_ci);
    assign w_hi = cla4(w_g[7:4], w_p[7:4], w_lo[4]);

    assign o_s  = {w_hi[3:0], w_lo[3:0]};
    assign o_co = w_hi[4];

endmodule

// File: rtl/add8_arbiter.sv
// Round-robin scheduler letting two clients share one cla8; result is held until acked.
//   state | meaning
//   IDLE  | waiting for a request; grant issued combinationally, operands latched at edge
//   EXEC  | cla8 working on latched operands; sum/carry registered at edge
//   DONE  | result valid on s/co/id; leaves on ack
module add8_arbiter
    import add8_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic       ci0,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    input  logic       ci1,
    input  logic       ack,
    output logic       gnt0,
    output logic       gnt1,
    output logic [7:0] s,
    output logic       co,
    output logic       id,
    output logic       done
);

    logic [1:0] r_state;
    logic       r_last;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic       r_ci;
    logic       r_own;
    logic [7:0] r_s;
    logic       r_co;
    logic       r_id;

    logic       w_idle;
    logic       w_pick1;
    logic [7:0] w_sum;
    logic       w_co;

    // Gating with reset_n keeps grants low while reset is held, even with requests up.
    assign w_idle  = (r_state == ST_IDLE) && reset_n;
    assign w_pick1 = rr_pick1(req0, req1, r_last);
    assign gnt1    = w_idle && w_pick1;
    assign gnt0    = w_idle && req0 && !w_pick1;

    cla8 u_cla8 (
        .i_a  (r_a),
        .i_b  (r_b),
        .i_ci (r_ci),
        .o_s  (w_sum),
        .o_co (w_co)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_last  <= LAST_RST;
            r_a     <= '0;
            r_b     <= '0;
            r_ci    <= 1'b0;
            r_own   <= 1'b0;
            r_s     <= '0;
            r_co    <= 1'b0;
            r_id    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (gnt0 || gnt1) begin
                        r_a     <= gnt1 ? a1 : a0;
                        r_b     <= gnt1 ? b1 : b0;
                        r_ci    <= gnt1 ? ci1 : ci0;
                        r_own   <= gnt1;
                        r_last  <= gnt1;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_s     <= w_sum;
                    r_co    <= w_co;
                    r_id    <= r_own;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (ack) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign s    = r_s;
    assign co   = r_co;
    assign id   = r_id;
    assign done = (r_state == ST_DONE);

endmodule
